// File: rtl/conv_sched.sv
// Tile scheduler for the convolution PE array: walks every (oc, ic) tile of one layer.
// Optional 2-entry packet prefetch FIFO enabled by CONV_SCHED_PREFETCH_EN.
module conv_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cfg_valid,
    input  logic [1:0]  i_cmd,
    input  logic [1:0]  i_layer,
    input  logic [5:0]  i_num_ic,
    input  logic [5:0]  i_num_oc,
    input  logic [79:0] i_params,
    input  logic        i_params_valid,
    output logic        o_params_ready,
    output logic        o_pe_start,
    output logic [71:0] o_pe_weights,
    output logic [7:0]  o_pe_bias,
    output logic        o_pe_first_ic,
    output logic        o_pe_last_ic,
    output logic [1:0]  o_pe_layer,
    input  logic        i_pe_done,
    output logic [5:0]  o_cur_ic,
    output logic [5:0]  o_cur_oc,
    output logic [2:0]  o_fsm,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_ABORT = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  layer_q, layer_d;
    logic [5:0]  num_ic_q, num_ic_d;
    logic [5:0]  num_oc_q, num_oc_d;
    logic [5:0]  ic_q, ic_d;
    logic [5:0]  oc_q, oc_d;
    logic [79:0] pbuf_q, pbuf_d;
    logic        err_q, err_d;

    logic        start_s, abort_s, idle_s, start_ok_s;
    logic        ready_s, take_s, drop_err_s;
    logic [79:0] pkt_s;
    logic        last_ic_s, last_oc_s, pe_active_s;

    assign start_s    = i_cfg_valid && (i_cmd == CMD_START);
    assign abort_s    = i_cfg_valid && (i_cmd == CMD_ABORT);
    assign idle_s     = (state_q == S_IDLE);
    assign start_ok_s = start_s && idle_s && (i_num_ic != 6'd0) && (i_num_oc != 6'd0);
    assign last_ic_s  = (ic_q == (num_ic_q - 6'd1));
    assign last_oc_s  = (oc_q == (num_oc_q - 6'd1));

`ifdef CONV_SCHED_PREFETCH_EN
    logic [79:0] fifo_q [2];
    logic [79:0] fifo_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        full_s, empty_s, pop_s, push_s, flush_s;

    assign full_s     = (cnt_q == 2'd2);
    assign empty_s    = (cnt_q == 2'd0);
    assign pop_s      = (state_q == S_LOAD) && !empty_s && !abort_s;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign ready_s    = !idle_s && (!full_s || pop_s);
    assign push_s     = i_params_valid && ready_s && !abort_s;
    assign drop_err_s = i_params_valid && !ready_s;
    assign flush_s    = start_ok_s || (abort_s && !idle_s);
    assign take_s     = pop_s;
    assign pkt_s      = fifo_q[rd_ptr_q];

    // Prefetch FIFO next-state: flush, push at tail, pop at head.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_s) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push_s) begin
                fifo_d[wr_ptr_q] = i_params;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Prefetch FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0] <= 80'd0;
            fifo_q[1] <= 80'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end
`else
    assign ready_s    = (state_q == S_LOAD);
    assign take_s     = i_params_valid && ready_s && !abort_s;
    assign drop_err_s = i_params_valid && !ready_s;
    assign pkt_s      = i_params;
`endif

    // Scheduler next-state: tile walk, command handling and sticky error.
    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        num_ic_d = num_ic_q;
        num_oc_d = num_oc_q;
        ic_d     = ic_q;
        oc_d     = oc_q;
        pbuf_d   = pbuf_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok_s) begin
                    layer_d  = i_layer;
                    num_ic_d = i_num_ic;
                    num_oc_d = i_num_oc;
                    ic_d     = 6'd0;
                    oc_d     = 6'd0;
                    state_d  = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (abort_s) begin
                    state_d = S_IDLE;
                end else if (take_s) begin
                    pbuf_d  = pkt_s;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_ISSUE: begin
                if (abort_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort_s) begin
                    state_d = S_IDLE;
                end else if (i_pe_done) begin
                    if (!last_ic_s) begin
                        ic_d    = ic_q + 6'd1;
                        state_d = S_LOAD;
                    end else if (!last_oc_s) begin
                        ic_d    = 6'd0;
                        oc_d    = oc_q + 6'd1;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort drops the tile position and the captured packet, not the command.
        if (abort_s && !idle_s) begin
            ic_d   = 6'd0;
            oc_d   = 6'd0;
            pbuf_d = 80'd0;
        end else begin
            pbuf_d = pbuf_d;
        end
        if ((start_s && !start_ok_s) || drop_err_s) begin
            err_d = 1'b1;
        end else if (start_ok_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Scheduler state and latched command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            layer_q  <= 2'd0;
            num_ic_q <= 6'd0;
            num_oc_q <= 6'd0;
            ic_q     <= 6'd0;
            oc_q     <= 6'd0;
            pbuf_q   <= 80'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            num_ic_q <= num_ic_d;
            num_oc_q <= num_oc_d;
            ic_q     <= ic_d;
            oc_q     <= oc_d;
            pbuf_q   <= pbuf_d;
            err_q    <= err_d;
        end
    end

    // Accumulate flags are only meaningful while a tile is in flight.
    assign pe_active_s    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign o_params_ready = ready_s;
    assign o_pe_start     = (state_q == S_ISSUE);
    assign o_pe_weights   = pbuf_q[71:0];
    assign o_pe_bias      = pbuf_q[79:72];
    assign o_pe_first_ic  = pe_active_s && (ic_q == 6'd0);
    assign o_pe_last_ic   = pe_active_s && last_ic_s;
    assign o_pe_layer     = layer_q;
    assign o_cur_ic       = ic_q;
    assign o_cur_oc       = oc_q;
    assign o_fsm          = state_q;
    assign o_busy         = (state_q == S_LOAD) || pe_active_s;
    assign o_done         = (state_q == S_DONE);
    assign o_err          = err_q;

endmodule
